// File: rtl/lcd_draw_pkg.sv
// Shared widths, FSM encoding and arbitration-mode constants for the LCD draw arbiter.
package lcd_draw_pkg;

  localparam int X_W  = 8;
  localparam int Y_W  = 9;
  localparam int ID_W = 4;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_LAUNCH     = 2'd1,
    ST_WAIT_READY = 2'd2,
    ST_DONE       = 2'd3
  } draw_state_e;

  // One requester's draw operands, latched as a unit at grant.
  typedef struct packed {
    logic [X_W-1:0]  x;
    logic [Y_W-1:0]  y;
    logic [ID_W-1:0] id;
  } draw_op_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/draw_grant_select.sv
// Combinational winner picker: fixed priority (lowest index) or round-robin
// searching upward from start_idx and wrapping to 0.
module draw_grant_select import lcd_draw_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   start_idx,
  input  logic               rr_mode,
  output logic               valid,
  output logic [IDX_W-1:0]   index
);

  // Later assignments override earlier ones, so each loop runs high-to-low
  // and the lowest qualifying index ends up as the pick. In RR mode the
  // at-or-after-start pass runs last so it beats the wrapped pass.
  always_comb begin
    valid = |req;
    index = '0;
    if (rr_mode) begin
      for (int i = NUM_REQ-1; i >= 0; i--) begin
        if (req[i] && (IDX_W'(i) < start_idx)) index = IDX_W'(i);
      end
      for (int i = NUM_REQ-1; i >= 0; i--) begin
        if (req[i] && (IDX_W'(i) >= start_idx)) index = IDX_W'(i);
      end
    end else begin
      for (int i = NUM_REQ-1; i >= 0; i--) begin
        if (req[i]) index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/lcd_draw_arbiter.sv
// Shares one DrawMif draw port between NUM_REQ sprite requesters: pick a
// winner, latch its operands, hold draw for the settle window, wait for
// readyLCD (bounded by a timeout), then pulse a one-cycle ack.
module lcd_draw_arbiter import lcd_draw_pkg::*; #(
  parameter  int NUM_REQ        = 4,
  parameter  int ARB_MODE       = 0,
  parameter  int SETTLE_CYCLES  = 21,
  parameter  int TIMEOUT_CYCLES = 4000000,
  localparam int IDX_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*X_W-1:0]   reqX,
  input  logic [NUM_REQ*Y_W-1:0]   reqY,
  input  logic [NUM_REQ*ID_W-1:0]  reqId,
  output logic [NUM_REQ-1:0]       ack,
  output logic                     busy,
  output logic [IDX_W-1:0]         grantIdx,
  output logic                     timeout,
  input  logic                     readyLCD,
  output logic                     draw,
  output logic [X_W-1:0]           xOrigin,
  output logic [Y_W-1:0]           yOrigin,
  output logic [ID_W-1:0]          ROMId
);

  // One counter serves both the settle window and the ready timeout.
  localparam int CNT_W = $clog2(max_int(SETTLE_CYCLES, TIMEOUT_CYCLES) + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  draw_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 draw_q, draw_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 busy_q, busy_d;
  logic                 timeout_q, timeout_d;
  draw_op_t             op_q, op_d;
  logic [IDX_W-1:0]     grant_q, grant_d;
  // Round-robin search start: the index just after the last grant.
  logic [IDX_W-1:0]     rr_q, rr_d;

  draw_op_t             req_ops [NUM_REQ];
  logic                 win_vld;
  logic [IDX_W-1:0]     win_idx;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_ops
    assign req_ops[i] = {reqX[i*X_W +: X_W], reqY[i*Y_W +: Y_W], reqId[i*ID_W +: ID_W]};
  end

  draw_grant_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_sel (
    .req       (req),
    .start_idx (rr_q),
    .rr_mode   (ARB_MODE == ARB_RR),
    .valid     (win_vld),
    .index     (win_idx)
  );

  // Next-state and registered-output logic for the draw handshake.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    draw_d    = draw_q;
    ack_d     = '0;
    timeout_d = timeout_q;
    op_d      = op_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    case (state_q)
      ST_IDLE: begin
        // A busy DrawMif (ready low) blocks new grants entirely.
        if (win_vld && readyLCD) begin
          state_d = ST_LAUNCH;
          op_d    = req_ops[win_idx];
          grant_d = win_idx;
          draw_d  = 1'b1;
          cnt_d   = '0;
          rr_d    = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
      end
      ST_LAUNCH: begin
        // readyLCD is stale until DrawMif has seen the rising draw.
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_WAIT_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_READY: begin
        if (readyLCD) begin
          state_d        = ST_DONE;
          draw_d         = 1'b0;
          ack_d[grant_q] = 1'b1;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d        = ST_DONE;
          draw_d         = 1'b0;
          ack_d[grant_q] = 1'b1;
          timeout_d      = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        // Extra low cycle so the next draw is always a clean rising edge.
        state_d = ST_IDLE;
        draw_d  = 1'b0;
        cnt_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      draw_q    <= 1'b0;
      ack_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      op_q      <= '0;
      grant_q   <= '0;
      rr_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      draw_q    <= draw_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      op_q      <= op_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
    end
  end

  assign draw     = draw_q;
  assign ack      = ack_q;
  assign busy     = busy_q;
  assign timeout  = timeout_q;
  assign grantIdx = grant_q;
  assign xOrigin  = op_q.x;
  assign yOrigin  = op_q.y;
  assign ROMId    = op_q.id;

endmodule

// File: tb/tb_lcd_draw_arbiter.sv
// Scoreboard bench: a fixed-priority and a round-robin arbiter run side by
// side; stimulus predicts each round's grant sequence up front, a monitor
// emulates DrawMif ready and checks every ack against the prediction.
module tb_lcd_draw_arbiter;

  localparam int N     = 4;
  localparam int NDUT  = 2;
  localparam int S_P [NDUT] = '{21, 6};
  localparam int T_P [NDUT] = '{400, 100};
  localparam int STUCK = 1000000;

  typedef struct {
    int idx;
    int x;
    int y;
    int id;
    int len;
    bit to;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NDUT-1:0][N-1:0]   req = '0;
  logic [NDUT-1:0][N*8-1:0] rx  = '0;
  logic [NDUT-1:0][N*9-1:0] ry  = '0;
  logic [NDUT-1:0][N*4-1:0] rid = '0;
  logic [NDUT-1:0]          rdy = '1;
  logic [NDUT-1:0][N-1:0]   ack;
  logic [NDUT-1:0]          busy, tout, draw;
  logic [NDUT-1:0][1:0]     gi;
  logic [NDUT-1:0][7:0]     xo;
  logic [NDUT-1:0][8:0]     yo;
  logic [NDUT-1:0][3:0]     ido;

  exp_t q0[$];
  exp_t q1[$];
  int  n_chk = 0;
  int  n_pass = 0;
  int  rdy_r = 0;
  bit  rdy_block = 0;
  bit  hold_mode = 0;
  int  hold_lim = 0;
  int  ack_cnt [NDUT];
  int  run [NDUT];
  int  low [NDUT];
  int  last_len [NDUT];
  bit  seen [NDUT];
  bit  to_exp [NDUT];
  int  rr_ptr [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    lcd_draw_arbiter #(
      .NUM_REQ(N), .ARB_MODE(g), .SETTLE_CYCLES(S_P[g]), .TIMEOUT_CYCLES(T_P[g])
    ) u_dut (
      .clock(clk), .reset_n(rst_n), .req(req[g]), .reqX(rx[g]), .reqY(ry[g]),
      .reqId(rid[g]), .ack(ack[g]), .busy(busy[g]), .grantIdx(gi[g]),
      .timeout(tout[g]), .readyLCD(rdy[g]), .draw(draw[g]), .xOrigin(xo[g]),
      .yOrigin(yo[g]), .ROMId(ido[g])
    );
  end

  initial forever #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // DrawMif ready as seen during draw-high cycle k: stays up for the first
  // few cycles (DrawMif latency), low until cycle r, then high again.
  function automatic bit ready_at(input int k, input int r);
    return (k < 5) || (k >= r);
  endfunction

  // Draw-high length: settle window, then first ready, capped by timeout.
  task automatic predict_len(input int g, input int r, output int len, output bit t);
    bit found;
    found = 0;
    len = S_P[g] + T_P[g];
    t = 1;
    for (int k = S_P[g]; k < S_P[g] + T_P[g]; k++) begin
      if (!found && ready_at(k, r)) begin
        found = 1;
        len = k + 1;
        t = 0;
      end
    end
  endtask

  // Grant order: fixed picks lowest pending; RR scans from the slot after
  // the previous grant. Acked requesters leave the set unless held.
  task automatic push_round(input int g, input logic [N-1:0] mask, input int reps);
    logic [N-1:0] pend;
    int cur, c, base;
    exp_t e;
    pend = mask;
    for (int n = 0; n < reps; n++) begin
      base = (g == 1) ? rr_ptr[g] : 0;
      cur = -1;
      for (int j = 0; j < N; j++) begin
        c = (base + j) % N;
        if (pend[c] && cur < 0) cur = c;
      end
      if (g == 1) rr_ptr[g] = (cur + 1) % N;
      if (!hold_mode) pend[cur] = 1'b0;
      e.idx = cur;
      e.x   = int'(rx[g][8*cur +: 8]);
      e.y   = int'(ry[g][9*cur +: 9]);
      e.id  = int'(rid[g][4*cur +: 4]);
      predict_len(g, rdy_r, e.len, e.to);
      if (g == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  task automatic rand_ops();
    for (int g = 0; g < NDUT; g++) begin
      for (int i = 0; i < N; i++) begin
        rx[g][8*i +: 8]  = 8'($urandom);
        ry[g][9*i +: 9]  = 9'($urandom);
        rid[g][4*i +: 4] = 4'($urandom);
      end
    end
  endtask

  task automatic run_round(input logic [N-1:0] mask, input int r, input bit hold,
                           input int nhold, input int blk);
    int t;
    rdy_r = r;
    hold_mode = hold;
    hold_lim = nhold;
    for (int g = 0; g < NDUT; g++) begin
      ack_cnt[g] = 0;
      push_round(g, mask, hold ? nhold : $countones(mask));
    end
    if (blk > 0) begin
      rdy_block = 1;
      step();
    end
    for (int g = 0; g < NDUT; g++) req[g] = mask;
    if (blk > 0) begin
      repeat (blk) step();
      for (int g = 0; g < NDUT; g++) begin
        chk("no_grant_ready_low_draw", int'(draw[g]), 0);
        chk("no_grant_ready_low_busy", int'(busy[g]), 0);
      end
      rdy_block = 0;
    end else begin
      step();
      for (int g = 0; g < NDUT; g++) chk("grant_latency_draw", int'(draw[g]), 1);
    end
    t = 0;
    while ((q0.size() + q1.size()) != 0 && t < 6000) begin
      step();
      t++;
    end
    chk("round_complete_pending", q0.size() + q1.size(), 0);
    q0.delete();
    q1.delete();
    for (int g = 0; g < NDUT; g++) req[g] = '0;
    hold_mode = 0;
    step();
  endtask

  // Monitor: DrawMif ready emulation, draw timing and ack scoreboard.
  initial begin
    exp_t e;
    for (int g = 0; g < NDUT; g++) begin
      run[g] = 0; low[g] = 0; last_len[g] = 0; seen[g] = 0;
    end
    forever begin
      @(negedge clk);
      for (int g = 0; g < NDUT; g++) begin
        if (draw[g]) begin
          if (run[g] == 0) begin
            if (seen[g]) chk("draw_low_gap_ge2", int'(low[g] >= 2), 1);
            seen[g] = 1;
            if (!hold_mode) rx[g][8*gi[g] +: 8] = 8'($urandom);
          end
          rdy[g] = ready_at(run[g], rdy_r);
          run[g]++;
          low[g] = 0;
        end else begin
          if (run[g] > 0) last_len[g] = run[g];
          run[g] = 0;
          low[g]++;
          rdy[g] = !rdy_block;
        end
        if (ack[g] != '0) begin
          if ((g == 0 ? q0.size() : q1.size()) == 0) begin
            chk("unexpected_ack", int'(ack[g]), 0);
          end else begin
            if (g == 0) e = q0.pop_front();
            else e = q1.pop_front();
            to_exp[g] = to_exp[g] | e.to;
            chk("ack_onehot", int'(ack[g]), 1 << e.idx);
            chk("grant_idx", int'(gi[g]), e.idx);
            chk("x_origin", int'(xo[g]), e.x);
            chk("y_origin", int'(yo[g]), e.y);
            chk("rom_id", int'(ido[g]), e.id);
            chk("draw_high_len", last_len[g], e.len);
            chk("timeout_sticky", int'(tout[g]), int'(to_exp[g]));
            chk("busy_in_done", int'(busy[g]), 1);
          end
          if (hold_mode) begin
            ack_cnt[g]++;
            if (ack_cnt[g] == hold_lim) req[g] = '0;
          end else begin
            req[g] = req[g] & ~ack[g];
          end
        end
      end
    end
  end

  // Stimulus sequence.
  initial begin
    int t, sel, r;
    for (int g = 0; g < NDUT; g++) begin
      rr_ptr[g] = 0; to_exp[g] = 0;
    end
    repeat (3) step();
    for (int g = 0; g < NDUT; g++) begin
      chk("reset_draw", int'(draw[g]), 0);
      chk("reset_ack", int'(ack[g]), 0);
      chk("reset_busy", int'(busy[g]), 0);
      chk("reset_timeout", int'(tout[g]), 0);
      chk("reset_xorigin", int'(xo[g]), 0);
      chk("reset_grantidx", int'(gi[g]), 0);
    end
    rst_n = 1'b1;
    step();

    // Single draw with known operands; long ready-low window.
    rand_ops();
    for (int g = 0; g < NDUT; g++) begin
      rx[g][16 +: 8] = 8'd31;
      ry[g][18 +: 9] = 9'd132;
      rid[g][8 +: 4] = 4'd5;
    end
    run_round(4'b0100, 300, 0, 0, 0);

    // Simultaneous requests, early ready.
    rand_ops();
    run_round(4'b1011, 0, 0, 0, 0);

    // Ready low in IDLE blocks any grant until it rises.
    rand_ops();
    run_round(4'b0010, 12, 0, 0, 8);

    // Reset in the middle of WAIT_READY.
    rand_ops();
    rdy_r = STUCK;
    for (int g = 0; g < NDUT; g++) req[g] = 4'b0001;
    t = 0;
    while (run[0] < S_P[0] + 5 && t < 200) begin
      step();
      t++;
    end
    chk("reached_wait_ready", int'(run[0] >= S_P[0] + 5), 1);
    rst_n = 1'b0;
    for (int g = 0; g < NDUT; g++) req[g] = '0;
    step();
    for (int g = 0; g < NDUT; g++) begin
      chk("midreset_draw", int'(draw[g]), 0);
      chk("midreset_ack", int'(ack[g]), 0);
      chk("midreset_busy", int'(busy[g]), 0);
      chk("midreset_timeout", int'(tout[g]), 0);
      chk("midreset_xorigin", int'(xo[g]), 0);
      rr_ptr[g] = 0;
      to_exp[g] = 0;
    end
    repeat (2) step();
    rst_n = 1'b1;
    rdy_r = 0;
    step();

    // All four held continuously: RR rotates 0,1,2,3,0; fixed repeats 0.
    rand_ops();
    run_round(4'b1111, 0, 1, 5, 0);

    // Ready stuck low -> timeout, then the next request is still served.
    rand_ops();
    run_round(4'b0010, STUCK, 0, 0, 0);
    rand_ops();
    run_round(4'b0001, 0, 0, 0, 0);

    // Randomised rounds.
    for (int n = 0; n < 20; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 3) r = 0;
      else if (sel < 6) r = $urandom_range(5, 30);
      else if (sel < 9) r = $urandom_range(20, 130);
      else r = STUCK;
      rand_ops();
      run_round(4'($urandom_range(1, 15)), r, 0, 0, (sel == 4) ? 3 : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
